// File: rtl/stereo_pkg.sv
// Shared types and defaults for the stereo census / matching-cost path.
package stereo_pkg;

    localparam int IMG_WIDTH_DEF  = 256;
    localparam int IMG_HEIGHT_DEF = 256;
    localparam int DATA_W_DEF     = 8;
    localparam int CENSUS_W       = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef logic [CENSUS_W-1:0] census_t;

    // Raster position (0..8, centre = 4) feeding census bit b; bit7 is r1c0.
    function automatic int nb_idx(input int b);
        return ((7 - b) < 4) ? (7 - b) : (8 - b);
    endfunction

endpackage

// File: rtl/census_cmp3x3.sv
// Combinational 3x3 census: nine raster-ordered pixels in, eight neighbour bits out.
// Optional CENSUS_THRESH_EN: a bit is set only when centre exceeds neighbour by more than CENSUS_THRESH.
module census_cmp3x3
    import stereo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
`ifdef CENSUS_THRESH_EN
    ,parameter int CENSUS_THRESH = 2
`endif
) (
    input  logic [8:0][DATA_W-1:0] win,
    output census_t                census
);

    logic [DATA_W-1:0] ctr;
    assign ctr = win[4];

`ifdef CENSUS_THRESH_EN
    localparam logic [DATA_W:0] THR = (DATA_W+1)'(CENSUS_THRESH);
`endif

    for (genvar b = 0; b < CENSUS_W; b++) begin : g_bit
        localparam int IDX = nb_idx(b);
`ifdef CENSUS_THRESH_EN
        // Extra bit carries the borrow so a neighbour brighter than centre never sets the bit.
        logic [DATA_W:0] diff;
        assign diff      = {1'b0, ctr} - {1'b0, win[IDX]};
        assign census[b] = !diff[DATA_W] && (diff > THR);
`else
        assign census[b] = win[IDX] < ctr;
`endif
    end

endmodule

// File: rtl/left_census_window.sv
// Left-image 3x3 sliding window + census; throttles the line-buffer reader via o_read_request.
// Optional CENSUS_THRESH_EN adds parameter CENSUS_THRESH (see census_cmp3x3).
module left_census_window
    import stereo_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REQ_SLACK  = 3
`ifdef CENSUS_THRESH_EN
    ,parameter int CENSUS_THRESH = 2
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   i_row1,
    input  logic [DATA_W-1:0]   i_row2,
    input  logic [DATA_W-1:0]   i_row3,
    input  logic                i_valid,
    input  logic                i_ready,
    output logic                o_read_request,
    output logic [CENSUS_W-1:0] o_census,
    output logic [DATA_W-1:0]   o_center,
    output logic                o_valid,
    output logic                o_line_end,
    output logic                o_frame_end
);

    localparam int STAGES = 1;
    localparam int COL_W  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    // Request is registered, so downstream always sees at least one trailing code.
    if (IMG_WIDTH < 3 || IMG_HEIGHT < 1 || REQ_SLACK < 1) begin : g_bad_cfg
        $error("left_census_window: unsupported configuration");
    end

    state_t            state, state_nxt;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [STAGES:0]   vld_pipe;

    // Two stored columns per row; the incoming triple is the third (newest) column.
    logic [1:0][DATA_W-1:0] h1, h2, h3;
    logic [8:0][DATA_W-1:0] win;
    census_t                census_nxt;

    logic accept, line_last, win_done, frame_last;

    assign accept     = i_valid && (state != DONE);
    assign line_last  = (col == COL_W'(IMG_WIDTH - 1));
    assign win_done   = accept && (col >= COL_W'(2));
    assign frame_last = accept && line_last && (row == ROW_W'(IMG_HEIGHT - 1));
    assign vld_pipe[0] = win_done;
    assign o_valid     = vld_pipe[STAGES];

    assign win = {i_row3, h3[0], h3[1],
                  i_row2, h2[0], h2[1],
                  i_row1, h1[0], h1[1]};

    census_cmp3x3 #(
        .DATA_W        (DATA_W)
`ifdef CENSUS_THRESH_EN
        ,.CENSUS_THRESH(CENSUS_THRESH)
`endif
    ) u_cmp (
        .win    (win),
        .census (census_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_valid) state_nxt = RUN;
            RUN:     if (frame_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            col            <= '0;
            row            <= '0;
            h1             <= '0;
            h2             <= '0;
            h3             <= '0;
            vld_pipe[STAGES:1] <= '0;
            o_census       <= '0;
            o_center       <= '0;
            o_line_end     <= 1'b0;
            o_frame_end    <= 1'b0;
            o_read_request <= 1'b0;
        end else begin
            state              <= state_nxt;
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            o_line_end         <= win_done && line_last;
            o_frame_end        <= (state == DONE);
            o_read_request     <= (state_nxt == RUN) && i_ready;

            if (accept) begin
                h1 <= {h1[0], i_row1};
                h2 <= {h2[0], i_row2};
                h3 <= {h3[0], i_row3};
                if (line_last) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end

            if (win_done) begin
                o_census <= census_nxt;
                o_center <= h2[0];
            end

            if (state == DONE) begin
                col <= '0;
                row <= '0;
            end
        end
    end

endmodule

// File: tb/tb_left_census_window.sv
// Directed + randomized bench for left_census_window with a frame-level reference model.
module tb_left_census_window;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] i_row1, i_row2, i_row3;
    logic          i_valid, i_ready;
    logic          o_read_request;
    logic [7:0]    o_census;
    logic [DW-1:0] o_center;
    logic          o_valid, o_line_end, o_frame_end;

    always #5 clk = ~clk;

    left_census_window #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .DATA_W    (DW),
        .REQ_SLACK (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_row1        (i_row1),
        .i_row2        (i_row2),
        .i_row3        (i_row3),
        .i_valid       (i_valid),
        .i_ready       (i_ready),
        .o_read_request(o_read_request),
        .o_census      (o_census),
        .o_center      (o_center),
        .o_valid       (o_valid),
        .o_line_end    (o_line_end),
        .o_frame_end   (o_frame_end)
    );

    int n_chk = 0;
    int n_fail = 0;
    int n_dut_codes = 0;

    // Reference model: frame phase (0 idle, 1 running, 2 frame finished), position, current line pixels.
    int phase = 0;
    int mcol  = 0;
    int mrow  = 0;
    int ln[3][W];

    function automatic int rnd();
        return int'($urandom_range(0, 255));
    endfunction

    // Census of the window whose right-hand column is c, straight from the bit-order rule.
    function automatic logic [7:0] census_ref(input int c);
        logic [7:0] r;
        int k;
        int ctr;
        int p;
        r   = '0;
        k   = 7;
        ctr = ln[1][c-1];
        for (int rr = 0; rr < 3; rr++) begin
            for (int cc = 0; cc < 3; cc++) begin
                if (!(rr == 1 && cc == 1)) begin
                    p = ln[rr][c-2+cc];
`ifdef CENSUS_THRESH_EN
                    r[k] = ((ctr - p) > 2);
`else
                    r[k] = (p < ctr);
`endif
                    k--;
                end
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"},    32'(o_valid),        32'(0));
        chk({tag, "_census"},   32'(o_census),       32'(0));
        chk({tag, "_center"},   32'(o_center),       32'(0));
        chk({tag, "_line_end"}, 32'(o_line_end),     32'(0));
        chk({tag, "_frm_end"},  32'(o_frame_end),    32'(0));
        chk({tag, "_req"},      32'(o_read_request), 32'(0));
    endtask

    task automatic step(input bit v, input int a, input int b, input int c, input bit rdy);
        logic [7:0] ec, ectr;
        bit ev, ele, efe, ereq;
        @(negedge clk);
        i_valid = v;
        i_row1  = 8'(a);
        i_row2  = 8'(b);
        i_row3  = 8'(c);
        i_ready = rdy;
        @(posedge clk);
        #1;
        efe = (phase == 2);
        ev = 1'b0; ele = 1'b0; ec = '0; ectr = '0;
        if (phase == 2) begin
            phase = 0; mcol = 0; mrow = 0;
        end else if (v) begin
            phase = 1;
            ln[0][mcol] = a; ln[1][mcol] = b; ln[2][mcol] = c;
            if (mcol >= 2) begin
                ev   = 1'b1;
                ec   = census_ref(mcol);
                ectr = 8'(ln[1][mcol-1]);
                ele  = (mcol == W - 1);
            end
            if (mcol == W - 1) begin
                mcol = 0;
                if (mrow == H - 1) phase = 2;
                else mrow++;
            end else begin
                mcol++;
            end
        end
        ereq = (phase == 1) && rdy;
        if (o_valid === 1'b1) n_dut_codes++;
        chk("valid",     32'(o_valid),        32'(ev));
        chk("line_end",  32'(o_line_end),     32'(ele));
        chk("frame_end", 32'(o_frame_end),    32'(efe));
        chk("read_req",  32'(o_read_request), 32'(ereq));
        if (ev) begin
            chk("census", 32'(o_census), 32'(ec));
            chk("center", 32'(o_center), 32'(ectr));
        end
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        rst     = 1'b0;
        i_valid = 1'b0;
        #1;
        chk_zero(tag);
        phase = 0; mcol = 0; mrow = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int acc;
        int guard;
        bit v;
        rst = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_row1 = '0; i_row2 = '0; i_row3 = '0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Frame 1: flat 50 -> all-zero codes, 6 per line, frame_end after the last
        n_dut_codes = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                step(1'b1, 50, 50, 50, 1'b1);
        step(1'b0, 0, 0, 0, 1'b1);
        chk("codes_frame1", 32'(n_dut_codes), 32'(H * (W - 2)));

        // Frame 2, line 0: gradient window
        step(1'b1, 10, 40, 70, 1'b1);
        step(1'b1, 20, 50, 80, 1'b1);
        step(1'b1, 30, 60, 90, 1'b1);
        chk("grad_census", 32'(o_census), 32'(8'hF0));
        chk("grad_center", 32'(o_center), 32'(50));
        for (int c = 3; c < W; c++) step(1'b1, rnd(), rnd(), rnd(), 1'b1);

        // Line 1: same window with a 5-cycle i_valid gap before the third triple
        step(1'b1, 10, 40, 70, 1'b1);
        step(1'b1, 20, 50, 80, 1'b1);
        repeat (5) step(1'b0, rnd(), rnd(), rnd(), 1'b1);
        step(1'b1, 30, 60, 90, 1'b1);
        chk("gap_census", 32'(o_census), 32'(8'hF0));
        chk("gap_center", 32'(o_center), 32'(50));
        for (int c = 3; c < W; c++) step(1'b1, rnd(), rnd(), rnd(), 1'b1);

        // Line 2: i_ready low for 10 cycles while in-flight triples keep arriving
        for (int k = 0; k < 10; k++) step(k < 3, rnd(), rnd(), rnd(), 1'b0);
        chk("stall_req_low", 32'(o_read_request), 32'(0));
        for (int c = 3; c < W; c++) step(1'b1, rnd(), rnd(), rnd(), 1'b1);
        chk("stall_req_resume", 32'(o_read_request), 32'(1));

        // Line 3: random valid gaps and random ready
        acc = 0; guard = 0;
        while (acc < W && guard < 200) begin
            v = ($urandom_range(0, 3) != 0);
            step(v, rnd(), rnd(), rnd(), 1'($urandom_range(0, 1)));
            if (v) acc++;
            guard++;
        end
        chk("rand_line_done", 32'(acc), 32'(W));
        step(1'b0, 0, 0, 0, 1'b1);

        // Frame 3: reset mid-line at col 4, then restart from col 0
        for (int c = 0; c < 5; c++) step(1'b1, rnd(), rnd(), rnd(), 1'b1);
        chk("pre_reset_valid", 32'(o_valid), 32'(1));
        pulse_reset("midreset");
        step(1'b1, rnd(), rnd(), rnd(), 1'b1);
        step(1'b1, rnd(), rnd(), rnd(), 1'b1);
        chk("restart_no_code", 32'(o_valid), 32'(0));
        step(1'b1, rnd(), rnd(), rnd(), 1'b1);
        chk("restart_code", 32'(o_valid), 32'(1));

        // Threshold window: centre 50, top-row neighbours 49/48/47
        pulse_reset("reset2");
        step(1'b1, 49, 50, 50, 1'b1);
        step(1'b1, 48, 50, 50, 1'b1);
        step(1'b1, 47, 50, 50, 1'b1);
`ifdef CENSUS_THRESH_EN
        chk("thresh_census", 32'(o_census), 32'(8'h20));
`else
        chk("thresh_census", 32'(o_census), 32'(8'hE0));
`endif
        for (int c = 3; c < W; c++) step(1'b1, rnd(), rnd(), rnd(), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
